pixel_seq_ctrl: RTL and testbench



---
 rtl/pixel_seq_pkg.sv | 16 +
 rtl/pixel_ramp_gen.sv | 26 ++
 rtl/pixel_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_pixel_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_seq_pkg.sv
// Shared types and default phase lengths for the pixel sequencer.
package pixel_seq_pkg;

  typedef enum logic [2:0] {StIdle, StErase, StExpose, StConvert, StRead} state_t;

  localparam int unsigned DefErase   = 5;
  localparam int unsigned DefExpose  = 255;
  localparam int unsigned DefConvert = 255;
  localparam int unsigned DefRead    = 5;
  localparam int unsigned DefCntW    = 16;

  localparam int unsigned PixW = 8;
  typedef logic [PixW-1:0] pix_t;
  localparam pix_t PixMax = '1;

endpackage

// File: rtl/pixel_ramp_gen.sv
// 8-bit digital ramp for the conversion phase: clears to 0, counts up, sticks at full scale.
module pixel_ramp_gen
  import pixel_seq_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output pix_t value
);

  pix_t value_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (enable && (value_q != PixMax)) begin
      value_q <= value_q + 1'b1;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Erase/expose/convert/read sequencer for one pixel, with ramp drive and captured-code handshake.
module pixel_seq_ctrl
  import pixel_seq_pkg::*;
#(
  parameter int unsigned C_ERASE   = DefErase,
  parameter int unsigned C_EXPOSE  = DefExpose,
  parameter int unsigned C_CONVERT = DefConvert,
  parameter int unsigned C_READ    = DefRead,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cont,
  output logic        erase,
  output logic        expose,
  output logic        convert,
  output logic        read,
  output pix_t        bus_out,
  output logic        bus_oe,
  input  pix_t        bus_in,
  output pix_t        pix_value,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] LastErase   = CNT_W'(C_ERASE - 1);
  localparam logic [CNT_W-1:0] LastExpose  = CNT_W'(C_EXPOSE - 1);
  localparam logic [CNT_W-1:0] LastConvert = CNT_W'(C_CONVERT - 1);
  localparam logic [CNT_W-1:0] LastRead    = CNT_W'(C_READ - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_last;
  logic             ramp_en;
  logic             ramp_clr;

  always_comb begin
    phase_last = 1'b0;
    unique case (state_q)
      StErase:   phase_last = (cnt_q == LastErase);
      StExpose:  phase_last = (cnt_q == LastExpose);
      StConvert: phase_last = (cnt_q == LastConvert);
      StRead:    phase_last = (cnt_q == LastRead);
      default:   phase_last = 1'b0;
    endcase
  end

  // Ramp counts through CONVERT and is cleared on the last cycle so it reads 0 after leaving.
  assign ramp_en  = (state_q == StConvert) && !phase_last;
  assign ramp_clr = !ramp_en;

  pixel_ramp_gen u_ramp (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ramp_clr),
    .enable  (ramp_en),
    .value   (bus_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      erase     <= 1'b0;
      expose    <= 1'b0;
      convert   <= 1'b0;
      read      <= 1'b0;
      bus_oe    <= 1'b0;
      busy      <= 1'b0;
      pix_value <= '0;
      pix_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
      end
      cnt_q <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          // Registered pix_valid blocks a restart until the edge after acceptance.
          if ((start || cont) && !pix_valid) begin
            state_q <= StErase;
            erase   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        StErase: begin
          if (phase_last) begin
            state_q <= StExpose;
            erase   <= 1'b0;
            expose  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StExpose: begin
          if (phase_last) begin
            state_q <= StConvert;
            expose  <= 1'b0;
            convert <= 1'b1;
            bus_oe  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StConvert: begin
          if (phase_last) begin
            state_q <= StRead;
            convert <= 1'b0;
            bus_oe  <= 1'b0;
            read    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StRead: begin
          if (phase_last) begin
            state_q   <= StIdle;
            read      <= 1'b0;
            busy      <= 1'b0;
            pix_value <= bus_in;
            pix_valid <= 1'b1;
            frame_cnt <= frame_cnt + 1'b1;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Directed bench for pixel_seq_ctrl: phase-table frame checks plus handshake, reset and ramp corners.
module tb_pixel_seq_ctrl;
  import pixel_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start, cont, pix_ready;
  logic        erase, expose, convert, read, bus_oe, pix_valid, busy;
  pix_t        bus_out, bus_in, pix_value;
  logic [15:0] frame_cnt;

  logic        start2;
  logic        erase2, expose2, convert2, read2, bus_oe2, pix_valid2, busy2;
  pix_t        bus_out2, bus_in2, pix_value2;
  logic [15:0] frame_cnt2;

  always #5 clk = ~clk;

  pixel_seq_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .cont      (cont),
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .read      (read),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .bus_in    (bus_in),
    .pix_value (pix_value),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  pixel_seq_ctrl #(
    .C_ERASE   (1),
    .C_EXPOSE  (2),
    .C_CONVERT (300),
    .C_READ    (2)
  ) u_dut_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start2),
    .cont      (1'b0),
    .erase     (erase2),
    .expose    (expose2),
    .convert   (convert2),
    .read      (read2),
    .bus_out   (bus_out2),
    .bus_oe    (bus_oe2),
    .bus_in    (bus_in2),
    .pix_value (pix_value2),
    .pix_valid (pix_valid2),
    .pix_ready (1'b1),
    .busy      (busy2),
    .frame_cnt (frame_cnt2)
  );

  // Pixel model, dv_pixel = 0.5: comparator trips once the ramp reaches half scale.
  localparam pix_t Threshold = 8'd128;
  pix_t sensor_code = '0;
  logic tripped = 1'b0;

  always @(posedge clk) begin
    if (erase) begin
      tripped     <= 1'b0;
      sensor_code <= '0;
    end else if (convert && !tripped && (bus_out >= Threshold)) begin
      tripped     <= 1'b1;
      sensor_code <= bus_out;
    end
  end

  assign bus_in  = bus_oe ? bus_out : (read ? sensor_code : 8'h00);
  assign bus_in2 = bus_oe2 ? bus_out2 : 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  int oe_read_overlap = 0;
  int multi_hot = 0;

  always @(negedge clk) begin
    if (bus_oe && read) oe_read_overlap++;
    if ($countones({erase, expose, convert, read}) > 1) multi_hot++;
    if ($countones({erase2, expose2, convert2, read2}) > 1) multi_hot++;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    n_checks++;
    if (actual < lo || actual > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Expected control vector {erase, expose, convert, read, busy, bus_oe, pix_valid}.
  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic       ramp;
    int         cycles;
  } phase_t;

  phase_t frame_tbl[6];

  task automatic set_rec(input int idx, input string name, input logic [6:0] ctl,
                         input logic ramp, input int cycles);
    frame_tbl[idx].name   = name;
    frame_tbl[idx].ctl    = ctl;
    frame_tbl[idx].ramp   = ramp;
    frame_tbl[idx].cycles = cycles;
  endtask

  // Pulses start, then walks the table one negedge at a time; needs pix_ready = 1.
  task automatic run_frame_table(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int r = 0; r < 6; r++) begin
      int bad = 0;
      int first_got = 0;
      for (int c = 0; c < frame_tbl[r].cycles; c++) begin
        int exp_bus;
        logic [6:0] got;
        @(negedge clk);
        exp_bus = frame_tbl[r].ramp ? ((c > 255) ? 255 : c) : 0;
        got = {erase, expose, convert, read, busy, bus_oe, pix_valid};
        if (got != frame_tbl[r].ctl || int'(bus_out) != exp_bus) begin
          if (bad == 0) first_got = int'(got);
          bad++;
        end
      end
      if (bad != 0) $display("  %s %s: first bad ctl vector %b", tag, frame_tbl[r].name, first_got[6:0]);
      check({tag, " ", frame_tbl[r].name, " bad cycles"}, bad, 0);
    end
  endtask

  task automatic wait_valid(input string name, input int limit);
    int w = 0;
    while (!pix_valid && w < limit) begin
      @(negedge clk);
      w++;
    end
    check({name, " pix_valid within bound"}, int'(pix_valid), 1);
  endtask

  initial begin
    pix_t held;
    int bad;
    int k;
    int w;
    int zero_mid;

    start     = 1'b0;
    cont      = 1'b0;
    pix_ready = 1'b1;
    start2    = 1'b0;

    set_rec(0, "erase",      7'b1000100, 1'b0, DefErase);
    set_rec(1, "expose",     7'b0100100, 1'b0, DefExpose);
    set_rec(2, "convert",    7'b0010110, 1'b1, DefConvert);
    set_rec(3, "read",       7'b0001100, 1'b0, DefRead);
    set_rec(4, "idle_valid", 7'b0000001, 1'b0, 1);
    set_rec(5, "idle",       7'b0000000, 1'b0, 3);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctl", int'({erase, expose, convert, read, busy, bus_oe, pix_valid}), 0);
    check("reset bus_out", int'(bus_out), 0);
    check("reset pix_value", int'(pix_value), 0);
    check("reset frame_cnt", int'(frame_cnt), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start busy", int'(busy), 0);

    // Single frame, default lengths
    run_frame_table("frame1");
    check("frame1 frame_cnt", int'(frame_cnt), 1);
    check_range("frame1 pix_value", int'(pix_value), 127, 128);

    // Backpressure with continuous mode
    cont      = 1'b1;
    pix_ready = 1'b0;
    wait_valid("bp frame", 2000);
    held = pix_value;
    check_range("bp pix_value", int'(held), 127, 128);
    check("bp frame_cnt", int'(frame_cnt), 2);
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (busy || erase || !pix_valid || pix_value != held) bad++;
    end
    check("bp hold bad cycles", bad, 0);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    check("bp accept pix_valid", int'(pix_valid), 0);
    check("bp accept erase", int'(erase), 0);
    @(negedge clk);
    check("bp restart erase", int'(erase), 1);
    cont = 1'b0;
    wait_valid("cont dropped frame", 2000);
    check("cont dropped frame_cnt", int'(frame_cnt), 3);
    pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("cont dropped stays idle", int'(busy), 0);
    check("cont dropped valid cleared", int'(pix_valid), 0);

    // Asynchronous reset at convert cycle 100
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    w = 0;
    while (!(convert && bus_out == 8'd99) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("reach convert cycle 100", int'(convert && bus_out == 8'd99), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset convert", int'(convert), 0);
    check("async reset bus_oe", int'(bus_oe), 0);
    check("async reset bus_out", int'(bus_out), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset frame_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_frame_table("after_reset");
    check("after_reset frame_cnt", int'(frame_cnt), 1);

    // Start held for the whole frame
    pix_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_valid("held start", 2000);
    check("held start frame_cnt", int'(frame_cnt), 2);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy || !pix_valid) bad++;
    end
    check("held start no restart", bad, 0);
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    check("held start accept erase", int'(erase), 0);
    @(negedge clk);
    check("held start restart erase", int'(erase), 1);
    start = 1'b0;
    wait_valid("held start second", 2000);
    check("held start second frame_cnt", int'(frame_cnt), 3);
    pix_ready = 1'b1;

    // Ramp saturation with a 300-cycle convert phase
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    w = 0;
    while (!convert2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("sat convert entered", int'(convert2), 1);
    k = 0;
    bad = 0;
    zero_mid = 0;
    while (convert2 && k < 400) begin
      if (int'(bus_out2) != ((k > 255) ? 255 : k)) bad++;
      if (k > 0 && bus_out2 == 8'd0) zero_mid++;
      if (!bus_oe2) bad++;
      k++;
      @(negedge clk);
    end
    check("sat ramp bad cycles", bad, 0);
    check("sat ramp zero mid-convert", zero_mid, 0);
    check("sat convert length", k, 300);
    check("sat bus_out after convert", int'(bus_out2), 0);
    check("sat bus_oe after convert", int'(bus_oe2), 0);
    w = 0;
    while (!pix_valid2 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("sat pix_valid", int'(pix_valid2), 1);
    check("sat frame_cnt", int'(frame_cnt2), 1);
    check("sat pix_value", int'(pix_value2), 0);
    check("sat busy after frame", int'(busy2), 0);

    check("bus_oe overlapping read cycles", oe_read_overlap, 0);
    check("multiple controls high cycles", multi_hot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
